// File: rtl/serial_config_mc.sv
// ============================================================================
// serial_config_mc : 3-wire serial configuration master with readback
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_config_mc #(
  parameter int                  DATA_W   = 16,
  parameter int                  ADDR_W   = 4,
  parameter int                  PREFIX_W = 12,
  parameter logic [PREFIX_W-1:0] PREFIX   = 12'h001,
  parameter int                  DIV_LOG2 = 4,
  parameter int                  NUM_CS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] config_data,
  input  logic [ADDR_W-1:0] config_addr,
  input  logic [3:0]        config_cs,
  input  logic              config_lsb_first,
  input  logic              config_start,
  output logic              config_idle,
  output logic              config_done,
  output logic              config_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              adc3wire_clk,
  output logic              adc3wire_data,
  output logic [NUM_CS-1:0] adc3wire_strobe,
  input  logic              adc3wire_sdi
);

  localparam int                    c_FRAME_W  = PREFIX_W + ADDR_W + DATA_W;
  localparam int                    c_BCNT_W   = $clog2(c_FRAME_W);
  localparam logic [c_BCNT_W-1:0]   c_LAST_BIT = c_BCNT_W'(c_FRAME_W - 1);
  localparam logic [DIV_LOG2-1:0]   c_HALF     = DIV_LOG2'(1) << (DIV_LOG2 - 1);
  localparam logic [4:0]            c_NUM_CS   = 5'(NUM_CS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DIV_LOG2-1:0]   r_cnt;
  logic [c_BCNT_W-1:0]   r_bit;
  logic [c_FRAME_W-1:0]  r_frame;
  logic [3:0]            r_cs;
  logic                  r_lsb;
  logic [DATA_W-1:0]     r_rd_shift;
  logic [DATA_W-1:0]     r_rd_data;
  logic                  r_idle;
  logic                  r_done;
  logic                  r_err;
  logic [NUM_CS-1:0]     r_strobe;
  logic [NUM_CS-1:0]     w_strobe_next;
  logic                  w_tick;
  logic                  w_cs_ok;

  assign w_tick  = (r_cnt == '1);
  assign w_cs_ok = ({1'b0, config_cs} < c_NUM_CS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_strobe_next = '1;
    case (r_state)
      S_IDLE:  if (config_start && w_cs_ok) w_state_next = S_SETUP;
      S_SETUP: if (w_tick) w_state_next = S_SHIFT;
      S_SHIFT: begin
        if (w_tick && (r_bit == c_LAST_BIT)) w_state_next = S_HOLD;
        for (int i = 0; i < NUM_CS; i++) begin
          if (r_cs == 4'(i)) w_strobe_next[i] = 1'b0;
        end
      end
      S_HOLD:  if (w_tick) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Strobes and idle are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_frame    <= '0;
      r_cs       <= '0;
      r_lsb      <= 1'b0;
      r_rd_shift <= '0;
      r_rd_data  <= '0;
      r_idle     <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_strobe   <= '1;
    end else begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_idle   <= (r_state == S_IDLE);
      r_strobe <= w_strobe_next;
      r_cnt    <= (r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (config_start) begin
            if (w_cs_ok) begin
              r_frame <= {PREFIX, config_addr, config_data};
              r_cs    <= config_cs;
              r_lsb   <= config_lsb_first;
              r_bit   <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (r_cnt == c_HALF) r_rd_shift <= (r_rd_shift << 1) | DATA_W'(adc3wire_sdi);
          if (w_tick) begin
            r_frame <= r_lsb ? (r_frame >> 1) : (r_frame << 1);
            r_bit   <= r_bit + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            r_done    <= 1'b1;
            r_rd_data <= r_rd_shift;
          end
        end
        default: ;
      endcase
    end
  end

  assign config_idle     = r_idle;
  assign config_done     = r_done;
  assign config_err      = r_err;
  assign rd_data         = r_rd_data;
  assign adc3wire_clk    = r_cnt[DIV_LOG2-1];
  assign adc3wire_strobe = r_strobe;
  assign adc3wire_data   = ((r_state == S_SETUP) || (r_state == S_SHIFT)) &&
                           (r_lsb ? r_frame[0] : r_frame[c_FRAME_W-1]);

endmodule

`default_nettype wire

// File: tb/tb_serial_config_mc.sv
// ============================================================================
// tb_serial_config_mc : scoreboard bench for the serial configuration master
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_config_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] config_data;
  logic [3:0]  config_addr;
  logic [3:0]  config_cs;
  logic        config_lsb_first;
  logic        config_start;
  logic        config_idle;
  logic        config_done;
  logic        config_err;
  logic [15:0] rd_data;
  logic        adc3wire_clk;
  logic        adc3wire_data;
  logic [1:0]  adc3wire_strobe;
  logic        adc3wire_sdi;

  serial_config_mc dut (
    .clk              (clk),
    .rst              (rst),
    .config_data      (config_data),
    .config_addr      (config_addr),
    .config_cs        (config_cs),
    .config_lsb_first (config_lsb_first),
    .config_start     (config_start),
    .config_idle      (config_idle),
    .config_done      (config_done),
    .config_err       (config_err),
    .rd_data          (rd_data),
    .adc3wire_clk     (adc3wire_clk),
    .adc3wire_data    (adc3wire_data),
    .adc3wire_strobe  (adc3wire_strobe),
    .adc3wire_sdi     (adc3wire_sdi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    logic [31:0] bits;
    logic [15:0] rd;
    int          done_cyc;
    int          low_start;
    logic [1:0]  mask;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // sdi driver: presents pattern bit k ahead of the k-th sampling edge
  logic [31:0] sdi_pat = '0;
  int          sk = 0;
  logic        prev_d = 1'b0;
  always @(negedge clk) begin
    if (rst || config_idle) begin
      sk = 0;
      adc3wire_sdi = 1'b0;
    end else if (adc3wire_strobe != 2'b11 && adc3wire_clk && !prev_d && sk < 32) begin
      adc3wire_sdi = sdi_pat[31-sk];
      sk++;
    end
    prev_d = adc3wire_clk;
  end

  // monitor: collects serial bits and pops the scoreboard on done/err
  logic [31:0] col = '0;
  int          nbits = 0, low_cnt = 0, first_low = -1;
  logic [1:0]  mask = '0;
  logic        prev_sclk = 1'b0;
  exp_t        e;
  always @(negedge clk) begin
    if (rst) begin
      col = '0; nbits = 0; low_cnt = 0; first_low = -1; mask = '0; prev_sclk = 1'b0;
    end else begin
      if (adc3wire_strobe != 2'b11) begin
        low_cnt++;
        mask = mask | ~adc3wire_strobe;
        if (first_low < 0) first_low = cyc;
        if (adc3wire_clk && !prev_sclk) begin
          col = {col[30:0], adc3wire_data};
          nbits++;
        end
      end
      prev_sclk = adc3wire_clk;
      if (config_done || config_err) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", {30'b0, config_done, config_err}, 32'd0);
        end else begin
          e = sbq.pop_front();
          if (e.is_err) begin
            chk("err_pulse", {30'b0, config_done, config_err}, 32'd1);
            chk("err_no_strobe", {30'b0, mask}, 32'd0);
          end else begin
            chk("done_only", {30'b0, config_done, config_err}, 32'd2);
            chk("serial_bits", col, e.bits);
            chk("bit_count", 32'(nbits), 32'd32);
            chk("strobe_mask", {30'b0, mask}, {30'b0, e.mask});
            chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
            chk("strobe_first_low", 32'(first_low), 32'(e.low_start));
            chk("strobe_low_cycles", 32'(low_cnt), 32'd512);
            chk("rd_data", {16'b0, rd_data}, {16'b0, e.rd});
          end
        end
        col = '0; nbits = 0; low_cnt = 0; first_low = -1; mask = '0;
      end
    end
  end

  // kind: 0 = no response expected, 1 = frame, 2 = error pulse
  task automatic issue(input logic [3:0] cs, input logic [3:0] addr, input logic [15:0] data,
                       input logic lsb, input int kind, input logic [31:0] bits,
                       input logic [15:0] rd);
    exp_t x;
    @(negedge clk);
    config_cs = cs; config_addr = addr; config_data = data;
    config_lsb_first = lsb; config_start = 1'b1;
    x.is_err    = (kind == 2);
    x.bits      = bits;
    x.rd        = rd;
    x.done_cyc  = cyc + 1 + 544;
    x.low_start = cyc + 1 + 17;
    x.mask      = 2'(1) << cs;
    if (kind != 0) sbq.push_back(x);
    @(posedge clk);
    @(negedge clk);
    config_start = 1'b0;
    config_data = ~data; config_addr = ~addr; config_lsb_first = ~lsb;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(negedge clk);
    while (!config_idle && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!config_idle) begin
      errors++;
      $display("FAIL idle_timeout: got idle %b expected 1", config_idle);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_busy;
    rst = 1'b1; config_data = '0; config_addr = '0; config_cs = '0;
    config_lsb_first = 1'b0; config_start = 1'b0; adc3wire_sdi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idle", {31'b0, config_idle}, 32'd1);
    chk("rst_strobe", {30'b0, adc3wire_strobe}, 32'd3);
    chk("rst_sclk", {31'b0, adc3wire_clk}, 32'd0);
    chk("rst_sdata", {31'b0, adc3wire_data}, 32'd0);
    chk("rst_done_err", {30'b0, config_done, config_err}, 32'd0);
    chk("rst_rd_data", {16'b0, rd_data}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // MSB-first frame on strobe 0
    sdi_pat = 32'h0;
    issue(4'd0, 4'h3, 16'hA5C3, 1'b0, 1, 32'h0013A5C3, 16'h0000);
    wait_idle();

    // same frame, LSB-first: bit-reversed order on the wire
    issue(4'd0, 4'h3, 16'hA5C3, 1'b1, 1, 32'hC3A5C800, 16'h0000);
    wait_idle();

    // strobe 1 with readback, plus a start request mid-frame that must be ignored
    sdi_pat = 32'h0000BEEF;
    issue(4'd1, 4'hA, 16'h1234, 1'b0, 1, 32'h001A1234, 16'hBEEF);
    repeat (300) @(negedge clk);
    config_cs = 4'd0; config_addr = 4'h5; config_start = 1'b1;
    @(negedge clk);
    config_start = 1'b0;
    wait_idle();
    sdi_pat = 32'h0;

    // out-of-range strobe index
    issue(4'd5, 4'h3, 16'hA5C3, 1'b0, 2, 32'h0, 16'h0);
    any_busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!config_idle || adc3wire_strobe != 2'b11) any_busy = 1'b1;
    end
    chk("err_stays_idle", {31'b0, any_busy}, 32'd0);

    // reset at cycle 200 of a frame
    issue(4'd0, 4'h3, 16'hA5C3, 1'b0, 0, 32'h0, 16'h0);
    repeat (200) @(negedge clk);
    chk("pre_rst_strobe", {30'b0, adc3wire_strobe}, 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst_strobe", {30'b0, adc3wire_strobe}, 32'd3);
    chk("midrst_sclk", {31'b0, adc3wire_clk}, 32'd0);
    chk("midrst_idle", {31'b0, config_idle}, 32'd1);
    chk("midrst_rd_data", {16'b0, rd_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);

    // normal frame after the aborted one
    issue(4'd0, 4'h3, 16'hA5C3, 1'b0, 1, 32'h0013A5C3, 16'h0000);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
